round_judge: RTL and testbench

//  Runs one round (one "life") of the rescue game and reports its outcome to

---
 rtl/round_judge.sv | 146 ++++++++++++++
 tb/tb_round_judge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_judge.sv
// One round of the rescue game: rescue target, countdown timer, outcome pulse.
// Optional LEVEL_TIME_SCALE_EN shortens round time at higher levels.
module round_judge #(
  parameter int unsigned ROUND_TIME  = 60,
  parameter int unsigned BASE_TARGET = 2,
  parameter int unsigned MIN_TIME    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick_1hz,
  input  logic [4:0] level,
  input  logic       rescue,
  input  logic       hit,
  input  logic       game_over,
  input  logic       game_won,
  output logic       finish,
  output logic       win,
  output logic [7:0] time_left,
  output logic [4:0] rescued,
  output logic [4:0] target,
  output logic       playing
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] time_left_q, time_left_d;
  logic [4:0] rescued_q, rescued_d;
  logic [4:0] target_q, target_d;
  logic       win_r_q, win_r_d;

  logic       can_start;
  logic [5:0] tgt_sum;
  logic [4:0] tgt_sat;
  logic [7:0] load_time;
  logic [5:0] resc_sum;
  logic [4:0] resc_inc;
  logic       goal_hit;
  logic       time_out;

  assign can_start = start && !game_over && !game_won;

  assign tgt_sum = {1'b0, level} + 6'(BASE_TARGET);
  assign tgt_sat = (tgt_sum > 6'd31) ? 5'd31 : tgt_sum[4:0];

`ifdef LEVEL_TIME_SCALE_EN
  logic [4:0]        lvl_eff;
  logic signed [8:0] scaled;
  assign lvl_eff = (level == 5'd0) ? 5'd1 : level;
  assign scaled  = $signed(9'(ROUND_TIME))
                 - $signed({3'b000, lvl_eff, 1'b0})
                 + 9'sd2;
  assign load_time = (scaled < $signed(9'(MIN_TIME)))
                   ? 8'(MIN_TIME) : scaled[7:0];
`else
  assign load_time = 8'(ROUND_TIME);
`endif

  assign resc_sum = {1'b0, rescued_q} + 6'd1;
  assign resc_inc = (rescued_q == 5'd31) ? 5'd31 : resc_sum[4:0];
  assign goal_hit = rescue && (resc_sum >= {1'b0, target_q});
  assign time_out = tick_1hz && (time_left_q == 8'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (can_start) state_d = PLAY;
      PLAY:    if (goal_hit || hit || time_out)
                 state_d = RESOLVE;
      RESOLVE: state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    finish  = (state_q == RESOLVE);
    win     = finish && win_r_q;
    playing = (state_q == PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_left_q <= 8'd0;
      rescued_q   <= 5'd0;
      target_q    <= 5'd0;
      win_r_q     <= 1'b0;
    end else begin
      time_left_q <= time_left_d;
      rescued_q   <= rescued_d;
      target_q    <= target_d;
      win_r_q     <= win_r_d;
    end
  end

  // Counters freeze outside PLAY until the next round loads them.
  always_comb begin
    time_left_d = time_left_q;
    rescued_d   = rescued_q;
    target_d    = target_q;
    win_r_d     = win_r_q;
    unique case (state_q)
      IDLE: begin
        if (can_start) begin
          time_left_d = load_time;
          rescued_d   = 5'd0;
          target_d    = tgt_sat;
          win_r_d     = 1'b0;
        end
      end
      PLAY: begin
        if (rescue) rescued_d = resc_inc;
        if (goal_hit) begin
          win_r_d = 1'b1;
        end else if (hit) begin
          win_r_d = 1'b0;
        end else if (time_out) begin
          time_left_d = 8'd0;
          win_r_d     = 1'b0;
        end else if (tick_1hz && time_left_q != 8'd0) begin
          time_left_d = time_left_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign time_left = time_left_q;
  assign rescued   = rescued_q;
  assign target    = target_q;

endmodule

// File: tb/tb_round_judge.sv
// Directed bench for round_judge with a finish/win scoreboard.
// Honours LEVEL_TIME_SCALE_EN when computing expected load times.
module tb_round_judge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [4:0] level = 5'd0;
  logic       rescue = 1'b0;
  logic       hit = 1'b0;
  logic       game_over = 1'b0;
  logic       game_won = 1'b0;
  logic       finish;
  logic       win;
  logic [7:0] time_left;
  logic [4:0] rescued;
  logic [4:0] target;
  logic       playing;

  typedef struct {
    logic       win;
    logic [4:0] resc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  round_judge dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tick_1hz  (tick_1hz),
    .level     (level),
    .rescue    (rescue),
    .hit       (hit),
    .game_over (game_over),
    .game_won  (game_won),
    .finish    (finish),
    .win       (win),
    .time_left (time_left),
    .rescued   (rescued),
    .target    (target),
    .playing   (playing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_time(input int lvl);
    int t;
`ifdef LEVEL_TIME_SCALE_EN
    int l;
    l = (lvl == 0) ? 1 : lvl;
    t = 60 - 2 * (l - 1);
    if (t < 20) t = 20;
`else
    t = 60;
`endif
    return t;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [4:0] r);
    exp_t e;
    e.win  = w;
    e.resc = r;
    sb.push_back(e);
  endtask

  task automatic go(input int lvl, input int exp_tgt);
    level = 5'(lvl);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("go_playing", playing, 1);
    chk("go_time", time_left, exp_time(lvl));
    chk("go_rescued", rescued, 0);
    chk("go_target", target, exp_tgt);
  endtask

  task automatic rpulse();
    rescue = 1'b1;
    cyc();
    rescue = 1'b0;
  endtask

  task automatic tpulse();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic settle();
    cyc();
    chk("post_finish", finish, 0);
    cyc();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (finish) begin
        if (sb.size() == 0) begin
          chk("unexp_finish", finish, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_win", win, e.win);
          chk("sb_rescued", rescued, e.resc);
        end
      end else if (win !== 1'b0) begin
        chk("win_no_finish", win, 0);
      end
    end
  end

  initial begin
    // reset held with start high
    reset = 1'b1;
    start = 1'b1;
    cyc();
    cyc();
    chk("rst_finish", finish, 0);
    chk("rst_win", win, 0);
    chk("rst_time", time_left, 0);
    chk("rst_rescued", rescued, 0);
    chk("rst_target", target, 0);
    chk("rst_playing", playing, 0);
    start = 1'b0;
    reset = 1'b0;
    cyc();
    chk("idle_playing", playing, 0);

    // win by rescues
    go(1, 3);
    rpulse();
    chk("w_r1", rescued, 1);
    rpulse();
    chk("w_r2", rescued, 2);
    push(1'b1, 5'd3);
    rpulse();
    chk("w_finish", finish, 1);
    chk("w_win", win, 1);
    chk("w_rescued", rescued, 3);
    settle();

    // timeout
    go(4, 6);
    for (int i = 0; i < exp_time(4) - 1; i++) tpulse();
    chk("to_time1", time_left, 1);
    chk("to_playing", playing, 1);
    push(1'b0, 5'd0);
    tpulse();
    chk("to_finish", finish, 1);
    chk("to_win", win, 0);
    chk("to_time0", time_left, 0);
    settle();
    chk("to_hold", time_left, 0);

    // rescue+hit+final tick with target one away
    go(1, 3);
    rpulse();
    rpulse();
    for (int i = 0; i < exp_time(1) - 1; i++) tpulse();
    push(1'b1, 5'd3);
    rescue = 1'b1;
    hit = 1'b1;
    tick_1hz = 1'b1;
    cyc();
    rescue = 1'b0;
    hit = 1'b0;
    tick_1hz = 1'b0;
    chk("s1_finish", finish, 1);
    chk("s1_win", win, 1);
    settle();

    // same but no prior rescues
    go(1, 3);
    for (int i = 0; i < exp_time(1) - 1; i++) tpulse();
    push(1'b0, 5'd1);
    rescue = 1'b1;
    hit = 1'b1;
    tick_1hz = 1'b1;
    cyc();
    rescue = 1'b0;
    hit = 1'b0;
    tick_1hz = 1'b0;
    chk("s2_finish", finish, 1);
    chk("s2_win", win, 0);
    chk("s2_rescued", rescued, 1);
    settle();

    // game_over blocks start
    game_over = 1'b1;
    start = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("go_block", playing, 0);
    game_over = 1'b0;
    game_won = 1'b1;
    cyc();
    cyc();
    chk("gw_block", playing, 0);
    game_won = 1'b0;
    start = 1'b0;
    cyc();

    // held start must not chain rounds
    level = 5'd0;
    start = 1'b1;
    cyc();
    chk("h_play", playing, 1);
    chk("h_target", target, 2);
    rpulse();
    push(1'b1, 5'd2);
    rpulse();
    chk("h_finish", finish, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("h_nochain", playing, 0);
    end
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    chk("h_replay", playing, 1);
    start = 1'b0;
    push(1'b0, 5'd0);
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    chk("h_hit_fin", finish, 1);
    settle();

    // level-scaled load times, target saturation path
    go(10, 12);
    push(1'b0, 5'd0);
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    settle();
    go(25, 27);
    push(1'b0, 5'd0);
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    settle();
    go(31, 31);
    push(1'b0, 5'd0);
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    settle();

    // reset mid-round
    go(3, 5);
    rpulse();
    tpulse();
    chk("mr_time", time_left, exp_time(3) - 1);
    reset = 1'b1;
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    reset = 1'b0;
    chk("mr_finish", finish, 0);
    chk("mr_playing", playing, 0);
    chk("mr_time0", time_left, 0);
    chk("mr_rescued", rescued, 0);
    chk("mr_target", target, 0);
    cyc();
    cyc();
    chk("mr_nofin", finish, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
